// File: rtl/adder_pkg.sv
// Types and width helpers shared between the operand collector and the adder.
package adder_pkg;
    localparam int BITS = 8;

    typedef logic [BITS-1:0] word_t;

    // Width of the partial-group counter: max(1, clog2(n)).
    function automatic int fill_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the emitted word count, which must be able to hold n itself.
    function automatic int words_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/operand_collector.sv
// Packs num serial operand words into one parallel group; the group appears the cycle after its last word is accepted.
// Stalls input (in_ready low) while a presented group is not taken; flush drops the partial group.
module operand_collector
    import adder_pkg::*;
#(
    parameter int bits = 8,
    parameter int num  = 2,
    localparam int FW  = fill_width(num),
    localparam int WW  = words_width(num)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [bits-1:0]           in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [num-1:0][bits-1:0]  o,
    output logic [WW-1:0]             words,
    output logic [FW-1:0]             fill,
    output logic                      valid_out,
    input  logic                      out_ready
);
    localparam logic [FW-1:0] LAST_SLOT = FW'(num - 1);

    logic [bits-1:0]          r_slot [num];
    logic [num-1:0][bits-1:0] r_o;
    logic [WW-1:0]            r_words;
    logic [FW-1:0]            r_fill;
    logic                     r_valid;

    logic w_accept;
    logic w_complete;

    assign in_ready   = rst_n && (!r_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    // A flushed word is consumed but never completes a group, even with in_last.
    assign w_complete = w_accept && !flush && ((r_fill == LAST_SLOT) || in_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_o     <= '0;
            r_words <= '0;
            r_fill  <= '0;
        end else begin
            if (w_complete) begin
                for (int k = 0; k < num; k++) begin
                    if (k < int'(r_fill))
                        r_o[k] <= r_slot[k];
                    else if (k == int'(r_fill))
                        r_o[k] <= in_data;
                    else
                        r_o[k] <= '0;
                end
                r_words <= WW'(r_fill) + WW'(1);
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end

            if (flush || w_complete)
                r_fill <= '0;
            else if (w_accept)
                r_fill <= r_fill + FW'(1);
        end
    end

    // Slot storage holds only words of an unfinished group, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept && !flush && !w_complete)
            r_slot[r_fill] <= in_data;
    end

    assign o         = r_o;
    assign words     = r_words;
    assign fill      = r_fill;
    assign valid_out = r_valid;
endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector with num=2 and num=3 instances and a group scoreboard.
module tb_operand_collector;
    typedef struct {
        logic [7:0] o0;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [1:0] words;
    } grp_t;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string tag, input bit ok,
                                input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // num = 2 instance
    logic            a_in_valid = 0, a_in_last = 0, a_flush = 0, a_out_ready = 1;
    logic [7:0]      a_in_data = 0;
    logic            a_in_ready, a_valid_out;
    logic [1:0][7:0] a_o;
    logic [1:0]      a_words;
    logic [0:0]      a_fill;

    // num = 3 instance
    logic            b_in_valid = 0, b_in_last = 0, b_flush = 0, b_out_ready = 1;
    logic [7:0]      b_in_data = 0;
    logic            b_in_ready, b_valid_out;
    logic [2:0][7:0] b_o;
    logic [1:0]      b_words;
    logic [1:0]      b_fill;

    operand_collector #(.bits(8), .num(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last),
        .in_ready(a_in_ready), .flush(a_flush),
        .o(a_o), .words(a_words), .fill(a_fill),
        .valid_out(a_valid_out), .out_ready(a_out_ready)
    );

    operand_collector #(.bits(8), .num(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
        .in_ready(b_in_ready), .flush(b_flush),
        .o(b_o), .words(b_words), .fill(b_fill),
        .valid_out(b_valid_out), .out_ready(b_out_ready)
    );

    grp_t qa[$];
    grp_t qb[$];
    int   b_vld_cycles = 0;

    function automatic grp_t mk(input logic [7:0] x0, input logic [7:0] x1,
                                input logic [7:0] x2, input logic [1:0] w);
        grp_t g;
        g.o0 = x0; g.o1 = x1; g.o2 = x2; g.words = w;
        return g;
    endfunction

    // Compare every group at the moment it is handed downstream.
    always @(negedge clk) begin
        grp_t e;
        if (a_valid_out && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_group", a_o === 16'h0, a_o, 16'h0);
            end else begin
                e = qa.pop_front();
                chk("a_o0", a_o[0] === e.o0, a_o[0], e.o0);
                chk("a_o1", a_o[1] === e.o1, a_o[1], e.o1);
                chk("a_words", a_words === e.words, a_words, e.words);
            end
        end
        if (b_valid_out) b_vld_cycles++;
        if (b_valid_out && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_group", b_o === 24'h0, b_o, 24'h0);
            end else begin
                e = qb.pop_front();
                chk("b_o0", b_o[0] === e.o0, b_o[0], e.o0);
                chk("b_o1", b_o[1] === e.o1, b_o[1], e.o1);
                chk("b_o2", b_o[2] === e.o2, b_o[2], e.o2);
                chk("b_words", b_words === e.words, b_words, e.words);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic last);
        int n = 0;
        while (!a_in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("a_ready_timeout", a_in_ready === 1'b1, a_in_ready, 1'b1);
        a_in_valid = 1; a_in_data = d; a_in_last = last;
        tick();
        a_in_valid = 0; a_in_last = 0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        b_in_valid = 1; b_in_data = d; b_in_last = last;
        tick();
        b_in_valid = 0; b_in_last = 0;
    endtask

    initial begin
        // Reset and idle
        repeat (2) tick();
        chk("ready_in_reset", a_in_ready === 1'b0, a_in_ready, 1'b0);
        rst_n = 1;
        #1;
        chk("rst_valid", a_valid_out === 1'b0, a_valid_out, 1'b0);
        chk("rst_o", a_o === 16'h0000, a_o, 16'h0000);
        chk("rst_words", a_words === 2'd0, a_words, 2'd0);
        chk("rst_fill", a_fill === 1'b0, a_fill, 1'b0);
        chk("rst_ready", a_in_ready === 1'b1, a_in_ready, 1'b1);
        chk("rst_b_o", b_o === 24'h0, b_o, 24'h0);

        // Basic group, presented for exactly one cycle
        qa.push_back(mk(8'h12, 8'h34, 8'h00, 2'd2));
        send_a(8'h12, 0);
        chk("basic_fill1", a_fill === 1'b1, a_fill, 1'b1);
        chk("basic_not_valid_yet", a_valid_out === 1'b0, a_valid_out, 1'b0);
        send_a(8'h34, 0);
        chk("basic_valid", a_valid_out === 1'b1, a_valid_out, 1'b1);
        chk("basic_fill0", a_fill === 1'b0, a_fill, 1'b0);
        tick();
        chk("basic_one_cycle", a_valid_out === 1'b0, a_valid_out, 1'b0);

        // Early terminate
        qa.push_back(mk(8'h7F, 8'h00, 8'h00, 2'd1));
        send_a(8'h7F, 1);
        chk("early_valid", a_valid_out === 1'b1, a_valid_out, 1'b1);
        tick();

        // Backpressure with a word waiting; it loads on the release edge
        a_out_ready = 0;
        qa.push_back(mk(8'h55, 8'h66, 8'h00, 2'd2));
        send_a(8'h55, 0);
        send_a(8'h66, 0);
        a_in_valid = 1; a_in_data = 8'h99; a_in_last = 1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", a_in_ready === 1'b0, a_in_ready, 1'b0);
            chk("bp_hold_o0", a_o[0] === 8'h55, a_o[0], 8'h55);
            chk("bp_hold_o1", a_o[1] === 8'h66, a_o[1], 8'h66);
            chk("bp_hold_valid", a_valid_out === 1'b1, a_valid_out, 1'b1);
            tick();
        end
        chk("bp_nothing_taken", a_fill === 1'b0, a_fill, 1'b0);
        a_out_ready = 1;
        qa.push_back(mk(8'h99, 8'h00, 8'h00, 2'd1));
        #1;
        chk("bp_ready_back", a_in_ready === 1'b1, a_in_ready, 1'b1);
        tick();
        a_in_valid = 0; a_in_last = 0;
        chk("bp_valid_stays", a_valid_out === 1'b1, a_valid_out, 1'b1);
        chk("bp_new_o0", a_o[0] === 8'h99, a_o[0], 8'h99);
        tick();
        chk("bp_drained", a_valid_out === 1'b0, a_valid_out, 1'b0);

        // Flush discards a partial group and a same-cycle in_last word
        send_a(8'hAA, 0);
        a_flush = 1;
        tick();
        a_flush = 0;
        chk("flush_fill", a_fill === 1'b0, a_fill, 1'b0);
        a_flush = 1;
        send_a(8'hBB, 1);
        a_flush = 0;
        chk("flush_last_dropped", a_valid_out === 1'b0, a_valid_out, 1'b0);
        qa.push_back(mk(8'h01, 8'h02, 8'h00, 2'd2));
        send_a(8'h01, 0);
        send_a(8'h02, 0);
        tick();

        // num = 3 streaming, six words back to back
        qb.push_back(mk(8'd1, 8'd2, 8'd3, 2'd3));
        qb.push_back(mk(8'd4, 8'd5, 8'd6, 2'd3));
        b_vld_cycles = 0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 3) chk("b_fill2", b_fill === 2'd2, b_fill, 2'd2);
            b_in_valid = 1; b_in_data = 8'(i);
            tick();
        end
        b_in_valid = 0;
        repeat (3) tick();
        chk("b_valid_cycles", b_vld_cycles == 2, b_vld_cycles, 2);

        // Early terminate with num = 3 pads the last slot
        qb.push_back(mk(8'h07, 8'h08, 8'h00, 2'd2));
        send_b(8'h07, 0);
        send_b(8'h08, 1);
        tick();

        // Reset mid-group discards it
        send_b(8'd1, 0);
        send_b(8'd2, 0);
        rst_n = 0;
        tick();
        chk("b_ready_in_reset", b_in_ready === 1'b0, b_in_ready, 1'b0);
        rst_n = 1;
        #1;
        chk("b_ready_after_reset", b_in_ready === 1'b1, b_in_ready, 1'b1);
        chk("b_fill_after_reset", b_fill === 2'd0, b_fill, 2'd0);
        b_vld_cycles = 0;
        repeat (4) tick();
        chk("b_no_group_after_reset", b_vld_cycles == 0, b_vld_cycles, 0);

        chk("qa_drained", qa.size() == 0, qa.size(), 0);
        chk("qb_drained", qb.size() == 0, qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
